// File: rtl/emern_fixed_pkg.sv
// Fixed-point constants and FSM state type shared by the inverse-determinant
// unit and the barycentric scaling stage.
package emern_fixed_pkg;

    localparam int unsigned DET_W    = 13;
    localparam int unsigned INV_FRAC = 23;
    localparam int unsigned ACC_W    = DET_W + INV_FRAC;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

endpackage

// File: rtl/tt_um_emern_serial_mul.sv
// Serial 13x23 unsigned shift-add multiplier: one multiplier bit per clock,
// LSB first. The done pulse follows the 13th step.
module tt_um_emern_serial_mul
    import emern_fixed_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DET_W-1:0]    multiplier,
    input  logic [INV_FRAC-1:0] multiplicand,
    output logic                busy,
    output logic                done,
    output logic [ACC_W-1:0]    product
);

    logic [DET_W-1:0] mplier;
    logic [ACC_W-1:0] mcand;
    logic [ACC_W-1:0] acc;
    logic [3:0]       step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mplier <= '0;
            mcand  <= '0;
            acc    <= '0;
            step   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mplier <= multiplier;
                mcand  <= ACC_W'(multiplicand);
                acc    <= '0;
                step   <= '0;
                busy   <= 1'b1;
            end else if (busy) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mplier <= mplier >> 1;
                mcand  <= mcand << 1;
                step   <= step + 4'd1;
                if (step == 4'(DET_W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/tt_um_emern_bary_scale.sv
// Barycentric weight |edge| * (1/det) as unsigned Q(OUT_FRAC) plus sign flag,
// saturated to 1.0. Define BARY_ROUND_EN to round half-up instead of truncating.
module tt_um_emern_bary_scale
    import emern_fixed_pkg::*;
#(
    parameter int unsigned OUT_FRAC = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DET_W-1:0]    edge_value,
    input  logic                inv_det_negative,
    input  logic [INV_FRAC-1:0] inv_det,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_FRAC:0]   weight,
    output logic                weight_negative,
    output logic                weight_sat
);

    localparam int unsigned SHIFT = INV_FRAC - OUT_FRAC;
    localparam logic [ACC_W:0] ONE = {{ACC_W{1'b0}}, 1'b1} << OUT_FRAC;

    state_t state, state_next;
    logic   sign, sign_next;
    logic   in_ready_next, out_valid_next;
    logic   weight_negative_next, weight_sat_next;
    logic [OUT_FRAC:0] weight_next;

    logic [DET_W-1:0] edge_mag;
    logic             accept;
    logic             mul_busy, mul_done;
    logic [ACC_W-1:0] product;
    logic [ACC_W:0]   acc_ext, raw;
    logic             sat;
    logic [OUT_FRAC:0] weight_calc;

    // Two's-complement magnitude; -4096 wraps to 13'h1000, read as unsigned 4096.
    assign edge_mag = edge_value[DET_W-1] ? (~edge_value + DET_W'(1)) : edge_value;
    assign accept   = (state == IDLE) && in_valid && in_ready && !mul_busy;

    tt_um_emern_serial_mul u_mul (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (accept),
        .multiplier   (edge_mag),
        .multiplicand (inv_det),
        .busy         (mul_busy),
        .done         (mul_done),
        .product      (product)
    );

`ifdef BARY_ROUND_EN
    localparam logic [ACC_W:0] ROUND_BIAS = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
    assign acc_ext = {1'b0, product} + ROUND_BIAS;
`else
    assign acc_ext = {1'b0, product};
`endif

    assign raw         = acc_ext >> SHIFT;
    assign sat         = raw > ONE;
    assign weight_calc = sat ? ONE[OUT_FRAC:0] : raw[OUT_FRAC:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            sign            <= 1'b0;
            in_ready        <= 1'b0;
            out_valid       <= 1'b0;
            weight          <= '0;
            weight_negative <= 1'b0;
            weight_sat      <= 1'b0;
        end else begin
            state           <= state_next;
            sign            <= sign_next;
            in_ready        <= in_ready_next;
            out_valid       <= out_valid_next;
            weight          <= weight_next;
            weight_negative <= weight_negative_next;
            weight_sat      <= weight_sat_next;
        end
    end

    always_comb begin
        state_next           = state;
        sign_next            = sign;
        in_ready_next        = in_ready;
        out_valid_next       = out_valid;
        weight_next          = weight;
        weight_negative_next = weight_negative;
        weight_sat_next      = weight_sat;
        unique case (state)
            IDLE: begin
                in_ready_next = 1'b1;
                if (accept) begin
                    in_ready_next = 1'b0;
                    sign_next     = edge_value[DET_W-1] ^ inv_det_negative;
                    state_next    = MUL;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_next           = DONE;
                    out_valid_next       = 1'b1;
                    weight_next          = weight_calc;
                    weight_sat_next      = sat;
                    weight_negative_next = sign && (weight_calc != '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    in_ready_next  = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tt_um_emern_bary_scale.sv
// Self-checking bench for tt_um_emern_bary_scale: directed cases, mid-operation
// reset, output stall, back-to-back streaming and randomized operands vs a model.
module tb_tt_um_emern_bary_scale;

    localparam int unsigned OF = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [12:0]   edge_value;
    logic          inv_det_negative;
    logic [22:0]   inv_det;
    logic          out_valid;
    logic          out_ready;
    logic [OF:0]   weight;
    logic          weight_negative;
    logic          weight_sat;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tt_um_emern_bary_scale #(.OUT_FRAC(OF)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .edge_value       (edge_value),
        .inv_det_negative (inv_det_negative),
        .inv_det          (inv_det),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .weight           (weight),
        .weight_negative  (weight_negative),
        .weight_sat       (weight_sat)
    );

    typedef struct {
        int          e;
        bit          nd;
        logic [22:0] inv;
        int          w;
        bit          neg;
        bit          sat;
    } dcase_t;

    // Reference: exact product of magnitude and Q23 fraction, rescaled to Q(OF).
    function automatic void model(input int e, input bit nd, input longint inv,
                                  output int w, output bit neg, output bit sat);
        longint mag;
        longint prod;
        longint raw;
        int     sh;
        sh   = 23 - OF;
        mag  = (e < 0) ? -longint'(e) : longint'(e);
        prod = mag * inv;
`ifdef BARY_ROUND_EN
        raw = (prod + (longint'(1) << (sh - 1))) >> sh;
`else
        raw = prod >> sh;
`endif
        sat = raw > (longint'(1) << OF);
        w   = sat ? (1 << OF) : int'(raw);
        neg = ((e < 0) != nd) && (w != 0);
    endfunction

    task automatic issue(input int e, input bit nd, input logic [22:0] inv);
        int n;
        @(negedge clk);
        edge_value       = e[12:0];
        inv_det_negative = nd;
        inv_det          = inv;
        in_valid         = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL issue_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (out_valid !== 1'b1 && lat < 40);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        edge_value = '0; inv_det = '0; inv_det_negative = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({in_ready, out_valid, weight, weight_negative, weight_sat} !== '0) begin
            fails++;
            $display("FAIL reset_values got rdy=%b vld=%b w=%0d neg=%b sat=%b required all 0",
                     in_ready, out_valid, weight, weight_negative, weight_sat);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_ready got %b required 0", in_ready);
        end
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL first_edge_ready got %b required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        dcase_t cases[6];
        int lat;
`ifdef BARY_ROUND_EN
        int third = 171;
`else
        int third = 170;
`endif
        cases[0] = '{ 2, 1'b0, 23'h200000, 128,   1'b0, 1'b0};
        cases[1] = '{-2, 1'b0, 23'h200000, 128,   1'b1, 1'b0};
        cases[2] = '{-2, 1'b1, 23'h200000, 128,   1'b0, 1'b0};
        cases[3] = '{ 2, 1'b0, 23'h2AAAAA, third, 1'b0, 1'b0};
        cases[4] = '{ 4, 1'b0, 23'h2AAAAA, 256,   1'b0, 1'b1};
        cases[5] = '{ 1, 1'b1, 23'h400000, 128,   1'b1, 1'b0};
        foreach (cases[i]) begin
            issue(cases[i].e, cases[i].nd, cases[i].inv);
            wait_result(lat);
            tests++;
            if (lat !== 14) begin
                fails++;
                $display("FAIL dir%0d_latency got %0d required 14", i, lat);
            end
            tests++;
            if (weight !== cases[i].w[OF:0] || weight_negative !== cases[i].neg ||
                weight_sat !== cases[i].sat) begin
                fails++;
                $display("FAIL dir%0d_result got w=%0d neg=%b sat=%b required w=%0d neg=%b sat=%b",
                         i, weight, weight_negative, weight_sat,
                         cases[i].w, cases[i].neg, cases[i].sat);
            end
            release_out();
        end
    endtask

    task automatic test_hold();
        int lat;
        issue(-4096, 1'b0, 23'h0);
        wait_result(lat);
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (out_valid !== 1'b1 || weight !== '0 || weight_negative !== 1'b0 ||
                weight_sat !== 1'b0 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold_cycle%0d got vld=%b w=%0d neg=%b sat=%b rdy=%b required vld=1 w=0 neg=0 sat=0 rdy=0",
                         c, out_valid, weight, weight_negative, weight_sat, in_ready);
            end
            @(negedge clk);
        end
        release_out();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL hold_release got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        issue(2, 1'b0, 23'h200000);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, out_valid, weight, weight_negative, weight_sat} !== '0) begin
            fails++;
            $display("FAIL midreset_values got rdy=%b vld=%b w=%0d neg=%b sat=%b required all 0",
                     in_ready, out_valid, weight, weight_negative, weight_sat);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL midreset_no_valid got %0d valid cycles required 0", seen);
        end
        issue(1, 1'b0, 23'h400000);
        wait_result(lat);
        tests++;
        if (weight !== 9'd128 || weight_negative !== 1'b0 || weight_sat !== 1'b0 || lat !== 14) begin
            fails++;
            $display("FAIL midreset_recover got w=%0d neg=%b sat=%b lat=%0d required w=128 neg=0 sat=0 lat=14",
                     weight, weight_negative, weight_sat, lat);
        end
        release_out();
    endtask

    task automatic test_random();
        int lat, e, w, d, mode;
        bit nd, neg, sat;
        logic [22:0] inv;
        logic [OF:0] held;
        for (int i = 0; i < 24; i++) begin
            e    = int'($urandom_range(8191)) - 4096;
            nd   = 1'($urandom_range(1));
            mode = int'($urandom_range(3));
            inv  = (mode == 0) ? 23'h0 : (mode == 1) ? 23'($urandom_range(4095)) : 23'($urandom);
            model(e, nd, longint'(inv), w, neg, sat);
            issue(e, nd, inv);
            wait_result(lat);
            tests++;
            if (lat !== 14 || weight !== w[OF:0] || weight_negative !== neg || weight_sat !== sat) begin
                fails++;
                $display("FAIL rand%0d e=%0d nd=%b inv=%h got w=%0d neg=%b sat=%b lat=%0d required w=%0d neg=%b sat=%b lat=14",
                         i, e, nd, inv, weight, weight_negative, weight_sat, lat, w, neg, sat);
            end
            held = weight;
            d = int'($urandom_range(3));
            for (int c = 0; c < d; c++) begin
                @(negedge clk);
                tests++;
                if (out_valid !== 1'b1 || weight !== held) begin
                    fails++;
                    $display("FAIL rand%0d_stall got vld=%b w=%0d required vld=1 w=%0d",
                             i, out_valid, weight, held);
                end
            end
            release_out();
        end
    endtask

    task automatic test_back_to_back();
        int exp_w[$];
        bit exp_n[$];
        bit exp_s[$];
        int accepts = 0, results = 0, last = -1, gap = -1, extra = 0;
        int e, w, ew;
        bit nd, neg, sat, pend, en, es;
        logic [22:0] inv;
        @(negedge clk);
        e = int'($urandom_range(8191)) - 4096; nd = 1'($urandom_range(1)); inv = 23'($urandom);
        edge_value = e[12:0]; inv_det_negative = nd; inv_det = inv;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 120 && results < 4; cyc++) begin
            if (cyc != 0) @(negedge clk);
            pend = 1'b0;
            if (out_valid === 1'b1) begin
                tests++;
                if (exp_w.size() == 0) begin
                    fails++;
                    $display("FAIL b2b_unexpected_result got w=%0d required no result", weight);
                end else begin
                    ew = exp_w.pop_front(); en = exp_n.pop_front(); es = exp_s.pop_front();
                    if (weight !== ew[OF:0] || weight_negative !== en || weight_sat !== es) begin
                        fails++;
                        $display("FAIL b2b_result%0d got w=%0d neg=%b sat=%b required w=%0d neg=%b sat=%b",
                                 results, weight, weight_negative, weight_sat, ew, en, es);
                    end
                end
                if (last >= 0) begin
                    tests++;
                    if (cyc - last < 15 || (gap >= 0 && cyc - last != gap)) begin
                        fails++;
                        $display("FAIL b2b_spacing got %0d required >=15 and equal to previous %0d",
                                 cyc - last, gap);
                    end
                    gap = cyc - last;
                end
                last = cyc;
                results++;
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                model(e, nd, longint'(inv), w, neg, sat);
                exp_w.push_back(w); exp_n.push_back(neg); exp_s.push_back(sat);
                accepts++;
                pend = 1'b1;
            end
            @(posedge clk);
            #1;
            if (pend) begin
                if (accepts == 4) begin
                    in_valid = 1'b0;
                end else begin
                    e = int'($urandom_range(8191)) - 4096; nd = 1'($urandom_range(1)); inv = 23'($urandom);
                    edge_value = e[12:0]; inv_det_negative = nd; inv_det = inv;
                end
            end
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) extra++;
        end
        out_ready = 1'b0;
        tests++;
        if (results != 4 || accepts != 4 || exp_w.size() != 0 || extra != 0) begin
            fails++;
            $display("FAIL b2b_counts got results=%0d accepts=%0d pending=%0d extra=%0d required 4 4 0 0",
                     results, accepts, exp_w.size(), extra);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
